// File: rtl/key_sum_ctrl_if.sv
// Button/selector bundle between the key front-end and whoever drives the keys.
// The key front-end is the slave: it samples the raw buttons and drives sum and key_flag.
interface key_sum_ctrl_if;
  logic       key_add;
  logic       key_sub;
  logic [2:0] sum;
  logic       key_flag;

  modport master (output key_add, key_sub, input sum, key_flag);
  modport slave  (input key_add, key_sub, output sum, key_flag);
endinterface

// File: rtl/key_sum_ctrl.sv
// Two debounced active-low buttons step a 3-bit wrap-around selector for the LED decoder.
// key_flag marks the first cycle in which sum holds a newly written value.
module key_sum_ctrl #(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter logic [2:0]  SUM_INIT  = 3'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  key_sum_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESS_FILTER, DOWN, RELEASE_FILTER} state_t;

  localparam logic [31:0] CNT_MAX = 32'(DB_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] press;
  logic [2:0] sum_q;
  logic       flag_q;

  function automatic logic [2:0] wrap_step(input logic [2:0] v, input logic up);
    return up ? v + 3'd1 : v - 3'd1;
  endfunction

  assign raw = {bus.key_sub, bus.key_add};

  // Stage p0/p1: two-flop synchroniser; idles high so a reset never looks like a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_key
    state_t      state;
    state_t      state_nxt;
    logic [31:0] cnt;
    logic [31:0] cnt_nxt;
    logic        press_q;
    logic        press_nxt;
    logic        k_s;

    assign k_s      = sync_p1[i];
    assign press[i] = press_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= IDLE;
        cnt     <= '0;
        press_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        press_q <= press_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      press_nxt = 1'b0;
      unique case (state)
        IDLE: begin
          if (!k_s) state_nxt = PRESS_FILTER;
        end
        PRESS_FILTER: begin
          if (k_s) begin
            state_nxt = IDLE;
          end else if (cnt == CNT_MAX) begin
            state_nxt = DOWN;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
        end
        DOWN: begin
          // Holding the key parks here; no auto-repeat
          if (k_s) state_nxt = RELEASE_FILTER;
        end
        RELEASE_FILTER: begin
          if (!k_s) begin
            state_nxt = DOWN;
          end else if (cnt == CNT_MAX) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p3: selector update; simultaneous add and sub cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= SUM_INIT;
      flag_q <= 1'b0;
    end else begin
      flag_q <= press[0] ^ press[1];
      if (press[0] ^ press[1]) sum_q <= wrap_step(sum_q, press[0]);
    end
  end

  assign bus.sum      = sum_q;
  assign bus.key_flag = flag_q;

endmodule

// File: tb/tb_key_sum_ctrl.sv
// Directed bench for key_sum_ctrl with a 16-cycle debounce window.
module tb_key_sum_ctrl;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   flag_seen;

  key_sum_ctrl_if kif ();

  key_sum_ctrl #(.DB_CYCLES(16), .SUM_INIT(3'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (kif.key_flag === 1'b1) flag_seen++;
    end
  endtask

  task automatic press_key(input bit add, input bit sub);
    if (add) kif.key_add = 1'b0;
    if (sub) kif.key_sub = 1'b0;
    tick(25);
    kif.key_add = 1'b1;
    kif.key_sub = 1'b1;
    tick(25);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    kif.key_add = 1'b1;
    kif.key_sub = 1'b1;
    rst_n = 1'b0;
    tick(3);
    n_tests++;
    if (kif.sum !== 3'd0 || kif.key_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_during: sum=%0d flag=%0b, want sum=0 flag=0", kif.sum, kif.key_flag);
    end
    rst_n = 1'b1;
    tick(3);
    n_tests++;
    if (kif.sum !== 3'd0 || kif.key_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: sum=%0d flag=%0b, want sum=0 flag=0", kif.sum, kif.key_flag);
    end
  endtask

  task automatic test_single_press();
    kif.key_add = 1'b0;
    tick(19);
    n_tests++;
    if (kif.sum !== 3'd0 || kif.key_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL press_early: after E18 sum=%0d flag=%0b, want 0/0", kif.sum, kif.key_flag);
    end
    tick(1);
    n_tests++;
    if (kif.sum !== 3'd1 || kif.key_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL press_e19: sum=%0d flag=%0b, want 1/1", kif.sum, kif.key_flag);
    end
    tick(1);
    n_tests++;
    if (kif.key_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL press_flag_width: flag=%0b, want 0", kif.key_flag);
    end
    flag_seen = 0;
    tick(200);
    n_tests++;
    if (kif.sum !== 3'd1 || flag_seen != 0) begin
      n_fail++;
      $display("FAIL press_hold: sum=%0d flags=%0d, want 1/0", kif.sum, flag_seen);
    end
    kif.key_add = 1'b1;
    tick(25);
  endtask

  task automatic test_bounce();
    flag_seen = 0;
    kif.key_add = 1'b0; tick(5);
    kif.key_add = 1'b1; tick(3);
    kif.key_add = 1'b0; tick(10);
    kif.key_add = 1'b1; tick(2);
    kif.key_add = 1'b0;
    tick(19);
    n_tests++;
    if (kif.sum !== 3'd1 || flag_seen != 0) begin
      n_fail++;
      $display("FAIL bounce_reject: sum=%0d flags=%0d, want 1/0", kif.sum, flag_seen);
    end
    tick(1);
    n_tests++;
    if (kif.sum !== 3'd2 || kif.key_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_accept: sum=%0d flag=%0b, want 2/1", kif.sum, kif.key_flag);
    end
    kif.key_add = 1'b1;
    tick(25);
  endtask

  task automatic test_wrap();
    logic [2:0] exp;
    apply_reset();
    n_tests++;
    if (kif.sum !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_reset: sum=%0d, want 0", kif.sum);
    end
    exp = 3'd0;
    for (int k = 0; k < 8; k++) begin
      exp = exp + 3'd1;
      flag_seen = 0;
      press_key(1'b1, 1'b0);
      n_tests++;
      if (kif.sum !== exp || flag_seen != 1) begin
        n_fail++;
        $display("FAIL wrap_add%0d: sum=%0d flags=%0d, want %0d/1", k, kif.sum, flag_seen, exp);
      end
    end
    flag_seen = 0;
    press_key(1'b0, 1'b1);
    n_tests++;
    if (kif.sum !== 3'd7 || flag_seen != 1) begin
      n_fail++;
      $display("FAIL wrap_sub: sum=%0d flags=%0d, want 7/1", kif.sum, flag_seen);
    end
  endtask

  task automatic test_both();
    flag_seen = 0;
    press_key(1'b1, 1'b1);
    n_tests++;
    if (kif.sum !== 3'd7 || flag_seen != 0) begin
      n_fail++;
      $display("FAIL both_keys: sum=%0d flags=%0d, want 7/0", kif.sum, flag_seen);
    end
  endtask

  task automatic test_release_bounce();
    kif.key_add = 1'b0;
    tick(25);
    n_tests++;
    if (kif.sum !== 3'd0) begin
      n_fail++;
      $display("FAIL relb_press: sum=%0d, want 0", kif.sum);
    end
    flag_seen = 0;
    kif.key_add = 1'b1; tick(8);
    kif.key_add = 1'b0; tick(4);
    kif.key_add = 1'b1; tick(30);
    n_tests++;
    if (kif.sum !== 3'd0 || flag_seen != 0) begin
      n_fail++;
      $display("FAIL relb_noextra: sum=%0d flags=%0d, want 0/0", kif.sum, flag_seen);
    end
    flag_seen = 0;
    press_key(1'b1, 1'b0);
    n_tests++;
    if (kif.sum !== 3'd1 || flag_seen != 1) begin
      n_fail++;
      $display("FAIL relb_next: sum=%0d flags=%0d, want 1/1", kif.sum, flag_seen);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) press_key(1'b1, 1'b0);
    n_tests++;
    if (kif.sum !== 3'd5) begin
      n_fail++;
      $display("FAIL rstmid_setup: sum=%0d, want 5", kif.sum);
    end
    kif.key_sub = 1'b0;
    tick(13);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (kif.sum !== 3'd0 || kif.key_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: sum=%0d flag=%0b, want 0/0", kif.sum, kif.key_flag);
    end
    tick(2);
    rst_n = 1'b1;
    flag_seen = 0;
    tick(19);
    n_tests++;
    if (kif.sum !== 3'd0 || flag_seen != 0) begin
      n_fail++;
      $display("FAIL rstmid_early: sum=%0d flags=%0d, want 0/0", kif.sum, flag_seen);
    end
    tick(1);
    n_tests++;
    if (kif.sum !== 3'd7 || kif.key_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_dec: sum=%0d flag=%0b, want 7/1", kif.sum, kif.key_flag);
    end
    kif.key_sub = 1'b1;
    tick(25);
    n_tests++;
    if (kif.sum !== 3'd7) begin
      n_fail++;
      $display("FAIL rstmid_final: sum=%0d, want 7", kif.sum);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    flag_seen = 0;
    rst_n       = 1'b0;
    kif.key_add = 1'b1;
    kif.key_sub = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_both();
    test_release_bounce();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/key_sum_ctrl.md
Name: key_sum_ctrl

Overview:
Front-end stage that feeds the LED pattern decoder. It takes two raw active-low push-buttons (increment, decrement), synchronises and debounces each one, and maintains a 3-bit wrap-around selector `sum`. The downstream LED decoder consumes `sum` directly. `key_flag` pulses once per accepted change.

Parameters:
DB_CYCLES, 1_000_000, consecutive stable clock cycles needed to accept a press or release (20 ms at 50 MHz); must be >= 2; benches override it to 16.
SUM_INIT, 3'd0, value loaded into sum at reset.

Ports:
clk  input  1  system clock, 50 MHz.
rst_n  input  1  reset; asynchronous, active-low.
key_add  input  1  raw increment button; 0 = pressed; asynchronous to clk.
key_sub  input  1  raw decrement button; 0 = pressed; asynchronous to clk.
sum  output  3  current selector value, registered.
key_flag  output  1  one-cycle pulse, high in the first cycle `sum` holds a new value.

Behaviour:
- Reset (asynchronous, active-low):
  - sum = SUM_INIT; key_flag = 0.
  - Both synchroniser flops = 1.
  - Both FSMs in IDLE; filter counters = 0; internal press pulses = 0.
  - Reset asserted mid-filter or mid-press abandons the event; no change to sum after release from reset.
- Synchroniser: two flops per key, so the FSM sees the key as `k_s`.
- Per-key FSM (identical instances for add and sub):
  - IDLE: k_s = 0 → PRESS_FILTER, cnt = 0.
  - PRESS_FILTER:
    - k_s = 1 → IDLE, cnt = 0 (bounce rejected).
    - k_s = 0 and cnt < DB_CYCLES-1 → cnt + 1.
    - k_s = 0 and cnt == DB_CYCLES-1 → DOWN, cnt = 0, press pulse = 1 for exactly one cycle.
  - DOWN: k_s = 1 → RELEASE_FILTER, cnt = 0. Holding the key produces no repeat.
  - RELEASE_FILTER:
    - k_s = 0 → DOWN, cnt = 0.
    - k_s = 1 and cnt == DB_CYCLES-1 → IDLE, cnt = 0.
    - Otherwise cnt + 1.
  - cnt is wide enough for DB_CYCLES-1 (32 bits acceptable).
- Sum update (edge after a press pulse):
  - Add pulse only: sum = sum + 1, modulo 8 (7 → 0).
  - Sub pulse only: sum = sum - 1, modulo 8 (0 → 7).
  - Both pulses in the same cycle: sum unchanged, key_flag = 0.
  - key_flag = 1 exactly when sum was written; 0 otherwise.
- Latency: let E0 be the first clk edge that samples the pin low. If the pin is then stable:
  - FSM enters PRESS_FILTER at E2.
  - Press pulse is set at E(DB_CYCLES+2).
  - sum and key_flag update at E(DB_CYCLES+3).
- Release acceptance: takes DB_CYCLES+2 edges after the pin rises. A new press is only recognised once the FSM is back in IDLE.
- The two keys are fully independent; one key held does not block the other.

Test Plan:
1. Reset, DB_CYCLES = 16 → sum = 0 and key_flag = 0 during and after reset. Hold key_add low → sum = 1 with key_flag high for 1 cycle, exactly 19 edges after E0. Keep holding for 200 cycles → no further change.
2. key_add bounces: 5 cycles low, 3 high, 10 low, 2 high, then steady low → glitches are rejected. Exactly one increment, timed from the start of the final steady low.
3. Eight clean add presses from 0 → sum goes 1..7 then 0, with eight key_flag pulses. Then one sub press from 0 → sum = 7.
4. Drive key_add and key_sub low on the same edge, both stable → both pulses coincide; sum unchanged and key_flag stays 0.
5. Bounce on release: from DOWN, release for 8 cycles, re-press for 4, then release → no extra increment; the next clean press increments by exactly 1.
6. Assert rst_n low while key_sub is in PRESS_FILTER (cnt = 10), with sum = 5 → sum = 0 immediately (asynchronous). Deassert while the key is still held → after 19 edges a single decrement gives sum = 7.
